// File: rtl/tt_stack_pkg.sv
// Shared definitions for the tt_stack request/response interface.
package tt_stack_pkg;

  localparam int unsigned TT_DW = 32;
  localparam int unsigned TT_AW = 8;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int unsigned ERR_OK    = 0;
  localparam int unsigned ERR_FULL  = 1;
  localparam int unsigned ERR_EMPTY = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } tt_state_e;

endpackage

// File: rtl/tt_result_fifo.sv
// First-word fall-through synchronous FIFO; DEPTH must be a power of two.
module tt_result_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          iclk,
  input  logic          ireset_n,
  input  logic          iwr,
  input  logic [DW-1:0] iwdata,
  input  logic          ird,
  output logic [DW-1:0] ordata,
  output logic          ovalid,
  output logic          ofull
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic          rd_en;

  assign ovalid = (cnt != '0);
  assign ofull  = (cnt == CW'(DEPTH));
  assign ordata = mem[rd_ptr];
  assign wr_en  = iwr & ~ofull;
  assign rd_en  = ird & ovalid;

  // Storage, pointers and occupancy; simultaneous write and read are allowed.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= iwdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/tt_stack_master.sv
// Initiator for the tt_stack request/response interface.
// Optional build macro TT_STACK_MASTER_GUARD_EN: drop commands the shadow
// depth shows to be illegal and count them without touching the stack.
module tt_stack_master
  import tt_stack_pkg::*;
#(
  parameter int unsigned DW           = TT_DW,
  parameter int unsigned AW           = TT_AW,
  parameter int unsigned RFIFO_DEPTH  = 2,
  parameter int unsigned RESP_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             iclk,
  input  logic             ireset_n,
  input  logic             icmd_valid,
  output logic             ocmd_ready,
  input  logic             icmd_op,
  input  logic [DW-1:0]    icmd_data,
  output logic             ostk_req_valid,
  input  logic             istk_ready,
  output logic             ostk_req_op,
  output logic [DW-1:0]    ostk_req_push_data,
  input  logic             istk_resp_valid,
  input  logic [DW-1:0]    istk_resp_pop_data,
  input  logic [DW-1:0]    istk_resp_error_code,
  input  logic             istk_max_valid,
  input  logic [DW-1:0]    istk_max_data,
  output logic             ores_valid,
  input  logic             ires_ready,
  output logic [DW-1:0]    ores_data,
  output logic             ores_is_max,
  output logic [DW-1:0]    ores_max_data,
  output logic [AW:0]      odepth,
  output logic [CNT_W-1:0] oerr_full_cnt,
  output logic [CNT_W-1:0] oerr_empty_cnt,
  output logic [CNT_W-1:0] oerr_timeout_cnt,
  output logic             obusy
);

  localparam int unsigned TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam int unsigned RW    = 2 * DW + 1;
  localparam logic [AW:0] DEPTH_MAX = {1'b1, {AW{1'b0}}};

  tt_state_e        state;
  logic             op_q;
  logic [DW-1:0]    data_q;
  logic [TMO_W-1:0] tmo_q;
  logic             run_q;
  logic             cmd_fire;
  logic             err_full;
  logic             err_empty;
  logic             guard_full;
  logic             guard_empty;
  logic             fifo_wr;
  logic             fifo_full;
  logic [RW-1:0]    fifo_wdata;
  logic [RW-1:0]    fifo_rdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Ready is decoded from registered state only; run_q keeps it low through reset.
  assign ocmd_ready         = run_q & (state == ST_IDLE) & ~fifo_full;
  assign cmd_fire           = icmd_valid & ocmd_ready;
  assign ostk_req_valid     = (state == ST_REQ);
  assign ostk_req_op        = op_q;
  assign ostk_req_push_data = data_q;
  assign obusy              = (state != ST_IDLE);

  // Codes other than full/empty are treated as success.
  assign err_full  = (istk_resp_error_code == DW'(ERR_FULL));
  assign err_empty = (istk_resp_error_code == DW'(ERR_EMPTY));

`ifdef TT_STACK_MASTER_GUARD_EN
  assign guard_empty = (icmd_op == OP_POP)  & (odepth == '0);
  assign guard_full  = (icmd_op == OP_PUSH) & (odepth == DEPTH_MAX);
`else
  assign guard_empty = 1'b0;
  assign guard_full  = 1'b0;
`endif

  assign fifo_wr    = (state == ST_WAIT_RESP) & istk_resp_valid;
  assign fifo_wdata = {istk_resp_pop_data, istk_max_valid, istk_max_data};

  // Command sequencing, shadow depth, error counters and response watchdog.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state            <= ST_IDLE;
      op_q             <= OP_PUSH;
      data_q           <= '0;
      tmo_q            <= '0;
      run_q            <= 1'b0;
      odepth           <= '0;
      oerr_full_cnt    <= '0;
      oerr_empty_cnt   <= '0;
      oerr_timeout_cnt <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (guard_empty) begin
              oerr_empty_cnt <= sat_inc(oerr_empty_cnt);
            end else if (guard_full) begin
              oerr_full_cnt <= sat_inc(oerr_full_cnt);
            end else begin
              op_q   <= icmd_op;
              data_q <= icmd_data;
              state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (istk_ready) begin
            if (err_full) begin
              oerr_full_cnt <= sat_inc(oerr_full_cnt);
              state         <= ST_IDLE;
            end else if (err_empty) begin
              oerr_empty_cnt <= sat_inc(oerr_empty_cnt);
              state          <= ST_IDLE;
            end else if (op_q == OP_PUSH) begin
              if (odepth != DEPTH_MAX) begin
                odepth <= odepth + (AW+1)'(1);
              end
              state <= ST_IDLE;
            end else begin
              tmo_q <= '0;
              state <= ST_WAIT_RESP;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (istk_resp_valid) begin
            if (odepth != '0) begin
              odepth <= odepth - (AW+1)'(1);
            end
            state <= ST_IDLE;
          end else if (tmo_q == TMO_W'(RESP_TIMEOUT - 1)) begin
            oerr_timeout_cnt <= sat_inc(oerr_timeout_cnt);
            state            <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result buffer; the IDLE credit check guarantees space for every write.
  tt_result_fifo #(
    .DW    (RW),
    .DEPTH (RFIFO_DEPTH)
  ) u_result_fifo (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iwr      (fifo_wr),
    .iwdata   (fifo_wdata),
    .ird      (ires_ready),
    .ordata   (fifo_rdata),
    .ovalid   (ores_valid),
    .ofull    (fifo_full)
  );

  assign ores_data     = fifo_rdata[RW-1 -: DW];
  assign ores_is_max   = fifo_rdata[DW];
  assign ores_max_data = fifo_rdata[DW-1:0];

endmodule

// File: tb/tb_tt_stack_master.sv
// Directed bench for tt_stack_master with a small behavioural stack on the far side.
module tb_tt_stack_master;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned CAP = 256;

  logic          iclk;
  logic          ireset_n;
  logic          icmd_valid;
  logic          ocmd_ready;
  logic          icmd_op;
  logic [DW-1:0] icmd_data;
  logic          ostk_req_valid;
  logic          istk_ready;
  logic          ostk_req_op;
  logic [DW-1:0] ostk_req_push_data;
  logic          istk_resp_valid;
  logic [DW-1:0] istk_resp_pop_data;
  logic [DW-1:0] istk_resp_error_code;
  logic          istk_max_valid;
  logic [DW-1:0] istk_max_data;
  logic          ores_valid;
  logic          ires_ready;
  logic [DW-1:0] ores_data;
  logic          ores_is_max;
  logic [DW-1:0] ores_max_data;
  logic [AW:0]   odepth;
  logic [15:0]   oerr_full_cnt;
  logic [15:0]   oerr_empty_cnt;
  logic [15:0]   oerr_timeout_cnt;
  logic          obusy;

  tt_stack_master #(.DW(DW), .AW(AW), .RFIFO_DEPTH(2), .RESP_TIMEOUT(15), .CNT_W(16)) dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready), .icmd_op(icmd_op), .icmd_data(icmd_data),
    .ostk_req_valid(ostk_req_valid), .istk_ready(istk_ready), .ostk_req_op(ostk_req_op),
    .ostk_req_push_data(ostk_req_push_data), .istk_resp_valid(istk_resp_valid),
    .istk_resp_pop_data(istk_resp_pop_data), .istk_resp_error_code(istk_resp_error_code),
    .istk_max_valid(istk_max_valid), .istk_max_data(istk_max_data),
    .ores_valid(ores_valid), .ires_ready(ires_ready), .ores_data(ores_data),
    .ores_is_max(ores_is_max), .ores_max_data(ores_max_data), .odepth(odepth),
    .oerr_full_cnt(oerr_full_cnt), .oerr_empty_cnt(oerr_empty_cnt),
    .oerr_timeout_cnt(oerr_timeout_cnt), .obusy(obusy)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Behavioural stack: combinational error code, one-cycle pop response.
  logic [DW-1:0] stk [CAP];
  int            sp;
  int            hs_cnt;
  logic          no_resp;
  logic [DW-1:0] force_code;
  logic          mdl_rv;
  logic          man_rv;
  logic [DW-1:0] mdl_pd;
  logic          mdl_mv;
  logic [DW-1:0] mdl_md;

  function automatic logic [DW-1:0] stk_max(input int n);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) if (stk[i] > m) m = stk[i];
    return m;
  endfunction

  always_comb begin
    istk_resp_error_code = '0;
    if (force_code != '0) istk_resp_error_code = force_code;
    else if (!ostk_req_op && sp == CAP) istk_resp_error_code = 32'd1;
    else if (ostk_req_op && sp == 0) istk_resp_error_code = 32'd2;
  end

  assign istk_resp_valid    = mdl_rv | man_rv;
  assign istk_resp_pop_data = mdl_pd;
  assign istk_max_valid     = mdl_mv;
  assign istk_max_data      = mdl_md;

  always @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      sp <= 0; hs_cnt <= 0; mdl_rv <= 1'b0; mdl_pd <= '0; mdl_mv <= 1'b0; mdl_md <= '0;
    end else begin
      mdl_rv <= 1'b0;
      if (ostk_req_valid && istk_ready) begin
        hs_cnt <= hs_cnt + 1;
        if (istk_resp_error_code != 32'd1 && istk_resp_error_code != 32'd2) begin
          if (!ostk_req_op) begin
            stk[sp] <= ostk_req_push_data;
            sp      <= sp + 1;
          end else begin
            mdl_pd <= stk[sp-1];
            mdl_mv <= (stk[sp-1] == stk_max(sp));
            mdl_md <= stk_max(sp);
            mdl_rv <= ~no_resp;
            sp     <= sp - 1;
          end
        end
      end
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge; returns cycles from accept to idle.
  task automatic issue(input logic op, input logic [DW-1:0] d, output int cyc);
    int w;
    icmd_op = op; icmd_data = d; icmd_valid = 1'b1;
    w = 0;
    while (!ocmd_ready && w < 50) begin
      @(posedge iclk); @(negedge iclk); w++;
    end
    if (!ocmd_ready) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
      icmd_valid = 1'b0;
      cyc = 0;
    end else begin
      @(posedge iclk); #1 icmd_valid = 1'b0;
      cyc = 1;
      @(negedge iclk);
      while (obusy && cyc < 60) begin
        cyc++; @(negedge iclk);
      end
    end
  endtask

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    logic [DW-1:0] fcode;
    int            cyc;
    int            depth;
    int            fullc;
    int            emptyc;
    logic          rv;
    logic [DW-1:0] rd;
    logic          rmax;
    logic [DW-1:0] rmd;
  } vec_t;

  vec_t vt [10];
  int   cyc;
  int   hs0;
  int   got_n;
  logic acc;
  logic bad;
  logic [DW-1:0] got [4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    icmd_valid = 1'b0; icmd_op = 1'b0; icmd_data = '0; istk_ready = 1'b1;
    ires_ready = 1'b0; no_resp = 1'b0; force_code = '0; man_rv = 1'b0;
    ireset_n = 1'b1;
    #1 ireset_n = 1'b0;

    //              op    data   fcode  cyc dep full emp  rv    rd     max   maxd
    vt[0] = '{1'b0, 32'h5,  32'h0, 2, 1, 0, 0, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h9,  32'h0, 2, 2, 0, 0, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h3,  32'h0, 2, 3, 0, 0, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[3] = '{1'b1, 32'h0,  32'h0, 3, 2, 0, 0, 1'b1, 32'h3,  1'b0, 32'h9};
    vt[4] = '{1'b1, 32'h0,  32'h0, 3, 1, 0, 0, 1'b1, 32'h9,  1'b1, 32'h9};
    vt[5] = '{1'b1, 32'h0,  32'h0, 3, 0, 0, 0, 1'b1, 32'h5,  1'b1, 32'h5};
    vt[6] = '{1'b1, 32'h0,  32'h0, 2, 0, 0, 1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[7] = '{1'b0, 32'h11, 32'h1, 2, 0, 1, 1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[8] = '{1'b0, 32'h22, 32'h3, 2, 1, 1, 1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[9] = '{1'b1, 32'h0,  32'h3, 3, 0, 1, 1, 1'b1, 32'h22, 1'b1, 32'h22};

    // Reset state
    #3;
    chk("rst_ocmd_ready", 64'(ocmd_ready), 64'd0);
    chk("rst_obusy", 64'(obusy), 64'd0);
    chk("rst_req_valid", 64'(ostk_req_valid), 64'd0);
    chk("rst_ores_valid", 64'(ores_valid), 64'd0);
    chk("rst_odepth", 64'(odepth), 64'd0);
    @(negedge iclk); @(negedge iclk);
    ireset_n = 1'b1;
    @(negedge iclk);
    chk("post_rst_ready", 64'(ocmd_ready), 64'd1);

    // Table-driven commands
    for (int i = 0; i < 10; i++) begin
      force_code = vt[i].fcode;
      issue(vt[i].op, vt[i].data, cyc);
      force_code = '0;
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vt[i].cyc));
      chk($sformatf("v%0d_depth", i), 64'(odepth), 64'(vt[i].depth));
      chk($sformatf("v%0d_full_cnt", i), 64'(oerr_full_cnt), 64'(vt[i].fullc));
      chk($sformatf("v%0d_empty_cnt", i), 64'(oerr_empty_cnt), 64'(vt[i].emptyc));
      chk($sformatf("v%0d_res_valid", i), 64'(ores_valid), 64'(vt[i].rv));
      if (vt[i].rv) begin
        chk($sformatf("v%0d_res_data", i), 64'(ores_data), 64'(vt[i].rd));
        chk($sformatf("v%0d_res_is_max", i), 64'(ores_is_max), 64'(vt[i].rmax));
        chk($sformatf("v%0d_res_max", i), 64'(ores_max_data), 64'(vt[i].rmd));
      end
      if (ores_valid) begin
        ires_ready = 1'b1;
        @(posedge iclk); #1 ires_ready = 1'b0;
        @(negedge iclk);
      end
    end
    chk("table_timeout_cnt", 64'(oerr_timeout_cnt), 64'd0);

    // Backpressure: two results buffered, third pop held off until drain
    issue(1'b0, 32'h1, cyc);
    issue(1'b0, 32'h2, cyc);
    issue(1'b0, 32'h3, cyc);
    issue(1'b1, 32'h0, cyc);
    issue(1'b1, 32'h0, cyc);
    chk("bp_ready_low", 64'(ocmd_ready), 64'd0);
    chk("bp_head", 64'(ores_data), 64'h3);
    icmd_op = 1'b1; icmd_valid = 1'b1;
    repeat (3) @(negedge iclk);
    chk("bp_not_accepted", 64'(obusy), 64'd0);
    ires_ready = 1'b1; got_n = 0; acc = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ores_valid && got_n < 4) begin got[got_n] = ores_data; got_n++; end
      if (icmd_valid && ocmd_ready) acc = 1'b1;
      @(posedge iclk); #1;
      if (acc) icmd_valid = 1'b0;
      @(negedge iclk);
    end
    ires_ready = 1'b0;
    icmd_valid = 1'b0;
    chk("bp_result_count", 64'(got_n), 64'd3);
    chk("bp_res0", 64'(got[0]), 64'h3);
    chk("bp_res1", 64'(got[1]), 64'h2);
    chk("bp_res2", 64'(got[2]), 64'h1);
    chk("bp_depth", 64'(odepth), 64'd0);

    // Stack stalls for 4 cycles during REQ
    istk_ready = 1'b0; hs0 = hs_cnt; bad = 1'b0;
    icmd_op = 1'b0; icmd_data = 32'h44; icmd_valid = 1'b1;
    @(posedge iclk); #1 icmd_valid = 1'b0;
    repeat (4) begin
      @(negedge iclk);
      if (!ostk_req_valid || ostk_req_op !== 1'b0 || ostk_req_push_data !== 32'h44) bad = 1'b1;
    end
    chk("stall_req_stable", 64'(bad), 64'd0);
    istk_ready = 1'b1;
    for (int w = 0; w < 20 && obusy; w++) @(negedge iclk);
    chk("stall_one_handshake", 64'(hs_cnt - hs0), 64'd1);
    chk("stall_depth", 64'(odepth), 64'd1);

    // Missing pop response: 15 cycles in WAIT_RESP, then timeout
    no_resp = 1'b1;
    issue(1'b1, 32'h0, cyc);
    chk("tmo_cycles", 64'(cyc), 64'd17);
    chk("tmo_cnt", 64'(oerr_timeout_cnt), 64'd1);
    chk("tmo_obusy", 64'(obusy), 64'd0);
    chk("tmo_no_result", 64'(ores_valid), 64'd0);
    chk("tmo_depth", 64'(odepth), 64'd1);

    // Reset while waiting for a response, then a late response
    no_resp = 1'b0;
    issue(1'b0, 32'h55, cyc);
    no_resp = 1'b1;
    icmd_op = 1'b1; icmd_valid = 1'b1;
    @(posedge iclk); #1 icmd_valid = 1'b0;
    repeat (3) @(negedge iclk);
    chk("pre_rst_in_wait", 64'({obusy, ostk_req_valid}), 64'b10);
    ireset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 64'({ocmd_ready, ostk_req_valid, ostk_req_op, ores_valid, ores_is_max, obusy}), 64'd0);
    chk("mid_rst_data", 64'(ostk_req_push_data | ores_data | ores_max_data), 64'd0);
    chk("mid_rst_cnts", 64'({odepth, oerr_full_cnt, oerr_empty_cnt, oerr_timeout_cnt}), 64'd0);
    @(negedge iclk);
    ireset_n = 1'b1; man_rv = 1'b1;
    @(negedge iclk);
    man_rv = 1'b0;
    @(negedge iclk);
    chk("late_resp_no_result", 64'(ores_valid), 64'd0);
    chk("late_resp_depth", 64'(odepth), 64'd0);
    chk("late_resp_idle", 64'(obusy), 64'd0);
    chk("late_resp_ready", 64'(ocmd_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_stack_master.md
Name: tt_stack_master

Overview:
- Initiator for the tt_stack request/response interface.
- Accepts push/pop commands from an upstream valid/ready stream and issues them to the stack one at a time.
- Collects pop data and max-tracking results into a small result FIFO for a downstream consumer.
- Keeps a shadow depth count, per-error counters and a response-timeout watchdog.

Parameters:
- DW, 32, data width; equals stack data width.
- AW, 8, stack address width; capacity 2**AW entries.
- RFIFO_DEPTH, 2, result FIFO entries; power of two, >=2.
- RESP_TIMEOUT, 15, cycles to wait for a pop response before declaring timeout.
- CNT_W, 16, width of the saturating error counters.

Ports:
- iclk  in  1  clock; single clock domain.
- ireset_n  in  1  asynchronous, active-low reset.
- icmd_valid  in  1  command valid.
- ocmd_ready  out  1  command accepted when icmd_valid & ocmd_ready.
- icmd_op  in  1  0 = push, 1 = pop.
- icmd_data  in  DW  push data; ignored for pop.
- ostk_req_valid  out  1  request valid to stack.
- istk_ready  in  1  stack ready.
- ostk_req_op  out  1  request op.
- ostk_req_push_data  out  DW  request push data.
- istk_resp_valid  in  1  pop response valid; arrives 1 cycle after the accepted pop.
- istk_resp_pop_data  in  DW  popped data.
- istk_resp_error_code  in  DW  combinational error code for the current request: 0 ok, 1 push-full, 2 pop-empty.
- istk_max_valid  in  1  popped value equals the current max.
- istk_max_data  in  DW  current max value.
- ores_valid  out  1  result available.
- ires_ready  in  1  downstream accepts result.
- ores_data  out  DW  popped data.
- ores_is_max  out  1  captured istk_max_valid.
- ores_max_data  out  DW  captured istk_max_data.
- odepth  out  AW+1  shadow stack depth.
- oerr_full_cnt  out  CNT_W  push-full error count.
- oerr_empty_cnt  out  CNT_W  pop-empty error count.
- oerr_timeout_cnt  out  CNT_W  timeout count.
- obusy  out  1  FSM not in IDLE.

Behaviour:
- Reset: ireset_n low clears all state and outputs asynchronously. FSM goes to IDLE; ostk_req_valid, ores_valid, obusy and ocmd_ready go to 0; odepth, all counters and FIFO pointers go to 0. Reset mid-request drops the request; a late response after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE:
  - ocmd_ready = 1 when the result FIFO has at least 1 free entry; otherwise 0 (this condition is applied to all commands, not only pops).
  - On accept: latch op/data into registers and go to REQ.
- REQ:
  - ostk_req_valid = 1; op and data are held stable until istk_ready = 1.
  - In the handshake cycle, sample istk_resp_error_code:
    - code 1: increment oerr_full_cnt; go to IDLE.
    - code 2: increment oerr_empty_cnt; go to IDLE.
    - code 0 push: odepth += 1; go to IDLE.
    - code 0 pop: go to WAIT_RESP.
  - Any other error code value is treated as 0.
- WAIT_RESP:
  - On istk_resp_valid: write {data, max_valid, max_data} into the FIFO, odepth -= 1, go to IDLE.
  - If no response arrives within RESP_TIMEOUT cycles: increment oerr_timeout_cnt, go to IDLE, no FIFO write.
  - istk_resp_valid seen outside WAIT_RESP is ignored.
- Throughput: push takes 2 cycles per command (accept + REQ) with istk_ready = 1; pop takes 3.
- ostk_req_* and ocmd_ready are registered/state-decoded; no combinational path from icmd_valid to ostk_req_valid.
- Counters saturate at 2**CNT_W-1. odepth never wraps: at most 2**AW, never below 0.
- Result FIFO: first-word fall-through; ores_* reflect the head entry. Same-cycle write and read are allowed. A write cannot overflow because of the IDLE credit check.

Optional Feature:
- TT_STACK_MASTER_GUARD_EN.
- Defined: in IDLE, a command that odepth shows is illegal (pop at 0, push at 2**AW) is accepted but never sent to the stack. The matching error counter increments in the accept cycle and the FSM stays in IDLE.
- Undefined: every command is forwarded, and errors are counted only from istk_resp_error_code.

Decomposition:
- Package tt_stack_pkg holds:
  - DW/AW defaults.
  - OP_PUSH = 0, OP_POP = 1.
  - ERR_OK = 0, ERR_FULL = 1, ERR_EMPTY = 2.
  - FSM state encoding.
- Sub-module tt_result_fifo: parameterised DW and depth; synchronous FIFO with the async active-low reset.

Test Plan:
- Push 0x5, 0x9, 0x3, then pop ×3 with ires_ready = 1 -> results 0x3, 0x9, 0x5; odepth goes 3→0; no error counts.
- Pop at depth 0 with guard undefined and stack returning code 2 -> oerr_empty_cnt = 1, no result, FSM back in IDLE in 2 cycles.
- Hold ires_ready = 0 and pop ×3 from depth 3 -> 2 results buffered; ocmd_ready = 0 before the 3rd command; after release, all 3 results arrive in order.
- Stack never asserts istk_resp_valid for a pop -> after 15 cycles in WAIT_RESP, oerr_timeout_cnt = 1 and obusy = 0.
- istk_ready low for 4 cycles during REQ -> ostk_req_* stable, exactly one request accepted.
- Drop ireset_n in WAIT_RESP, then deliver a response -> all outputs 0, response ignored, odepth = 0.
